// File: rtl/seg7_scan_capture.sv
// Seven-segment scan capture: debounces each strobed digit, decodes it back to BCD and delivers
// whole frames on a valid/ready handshake. Define SEG7_SYNC_EN to add a 2-flop input synchronizer.
module seg7_scan_capture #(
   parameter int unsigned N_DIGITS      = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg,
   input  logic [N_DIGITS-1:0]     dig_sel,
   output logic [4*N_DIGITS-1:0]   frame_bcd,
   output logic [N_DIGITS-1:0]     frame_bad,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic                    overrun
);

   localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

   typedef enum logic {StCollect, StPresent} state_e;

   logic [6:0]            seg_in;
   logic [N_DIGITS-1:0]   sel_in;

`ifdef SEG7_SYNC_EN
   logic [6:0]            seg_m_q, seg_y_q;
   logic [N_DIGITS-1:0]   sel_m_q, sel_y_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_m_q <= '0;
         seg_y_q <= '0;
         sel_m_q <= '0;
         sel_y_q <= '0;
      end else begin
         seg_m_q <= seg;
         seg_y_q <= seg_m_q;
         sel_m_q <= dig_sel;
         sel_y_q <= sel_m_q;
      end
   end

   assign seg_in = seg_y_q;
   assign sel_in = sel_y_q;
`else
   assign seg_in = seg;
   assign sel_in = dig_sel;
`endif

   logic [6:0]            s_seg_q, p_seg_q;
   logic [N_DIGITS-1:0]   s_sel_q, p_sel_q;
   logic [7:0]            cnt_q, cnt_d;
   logic [N_DIGITS-1:0]   captured_q, captured_d;
   logic [4*N_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
   logic [N_DIGITS-1:0]   shadow_bad_q, shadow_bad_d;
   logic [4*N_DIGITS-1:0] frame_bcd_q, frame_bcd_d;
   logic [N_DIGITS-1:0]   frame_bad_q, frame_bad_d;
   logic                  overrun_q, overrun_d;
   state_e                state_q, state_d;

   logic                  sel_onehot;
   logic                  same;
   logic                  latch;
   logic [N_DIGITS-1:0]   latch_mask;
   logic                  full;
   logic [3:0]            dec_bcd;
   logic                  dec_bad;

   assign sel_onehot = (s_sel_q != '0) && ((s_sel_q & (s_sel_q - N_DIGITS'(1))) == '0);
   assign same       = {s_seg_q, s_sel_q} == {p_seg_q, p_sel_q};

   always_comb begin
      cnt_d = '0;
      if (sel_onehot && same) begin
         cnt_d = (cnt_q >= StableMax) ? StableMax : cnt_q + 8'd1;
      end else if (sel_onehot) begin
         cnt_d = 8'd1;
      end
   end

   // Latch only on the transition into saturation, so one stable period yields one latch.
   assign latch      = sel_onehot && (cnt_d == StableMax) && (cnt_q != StableMax);
   assign latch_mask = latch ? s_sel_q : '0;
   assign full       = &captured_q;

   always_comb begin
      dec_bcd = 4'hF;
      dec_bad = 1'b0;
      unique case (s_seg_q)
         7'h7E: dec_bcd = 4'd0;
         7'h30: dec_bcd = 4'd1;
         7'h6D: dec_bcd = 4'd2;
         7'h79: dec_bcd = 4'd3;
         7'h33: dec_bcd = 4'd4;
         7'h5B: dec_bcd = 4'd5;
         7'h5F: dec_bcd = 4'd6;
         7'h70: dec_bcd = 4'd7;
         7'h7F: dec_bcd = 4'd8;
         7'h7B: dec_bcd = 4'd9;
         7'h00: dec_bcd = 4'hF;
         default: dec_bad = 1'b1;
      endcase
   end

   always_comb begin
      shadow_bcd_d = shadow_bcd_q;
      shadow_bad_d = shadow_bad_q;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (latch_mask[i]) begin
            shadow_bcd_d[4*i +: 4] = dec_bcd;
            shadow_bad_d[i]        = dec_bad;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      captured_d  = captured_q | latch_mask;
      frame_bcd_d = frame_bcd_q;
      frame_bad_d = frame_bad_q;
      overrun_d   = 1'b0;
      unique case (state_q)
         StCollect: begin
            if (full) begin
               frame_bcd_d = shadow_bcd_q;
               frame_bad_d = shadow_bad_q;
               captured_d  = latch_mask;
               state_d     = StPresent;
            end
         end
         StPresent: begin
            if (frame_ready) begin
               if (full) begin
                  frame_bcd_d = shadow_bcd_q;
                  frame_bad_d = shadow_bad_q;
                  captured_d  = latch_mask;
               end else begin
                  state_d = StCollect;
               end
            end else if (full) begin
               // Consumer still holds the previous frame: drop the new one.
               captured_d = latch_mask;
               overrun_d  = 1'b1;
            end
         end
         default: state_d = StCollect;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_seg_q      <= '0;
         s_sel_q      <= '0;
         p_seg_q      <= '0;
         p_sel_q      <= '0;
         cnt_q        <= '0;
         captured_q   <= '0;
         shadow_bcd_q <= '0;
         shadow_bad_q <= '0;
         frame_bcd_q  <= '0;
         frame_bad_q  <= '0;
         overrun_q    <= 1'b0;
         state_q      <= StCollect;
      end else begin
         s_seg_q      <= seg_in;
         s_sel_q      <= sel_in;
         p_seg_q      <= s_seg_q;
         p_sel_q      <= s_sel_q;
         cnt_q        <= cnt_d;
         captured_q   <= captured_d;
         shadow_bcd_q <= shadow_bcd_d;
         shadow_bad_q <= shadow_bad_d;
         frame_bcd_q  <= frame_bcd_d;
         frame_bad_q  <= frame_bad_d;
         overrun_q    <= overrun_d;
         state_q      <= state_d;
      end
   end

   assign frame_bcd   = frame_bcd_q;
   assign frame_bad   = frame_bad_q;
   assign frame_valid = (state_q == StPresent);
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: the script queues expected frames, a negedge monitor
// pops and compares them on every handshake. Timing checks account for SEG7_SYNC_EN latency.
module tb_seg7_scan_capture;

   localparam int ND = 4;
   localparam int SC = 4;
`ifdef SEG7_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [6:0]    seg = '0;
   logic [ND-1:0] dig_sel = '0;
   logic          frame_ready = 1'b0;
   logic [4*ND-1:0] frame_bcd;
   logic [ND-1:0] frame_bad;
   logic          frame_valid;
   logic          overrun;

   seg7_scan_capture #(
      .N_DIGITS      (ND),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg         (seg),
      .dig_sel     (dig_sel),
      .frame_bcd   (frame_bcd),
      .frame_bad   (frame_bad),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  bad;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ov_cnt   = 0;
   int   frames   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [15:0] bcd, input logic [3:0] bad);
      exp_t e;
      e.bcd = bcd;
      e.bad = bad;
      exp_q.push_back(e);
   endtask

   // Monitor: a handshake completes on the next rising edge when valid & ready here.
   always @(negedge clk) begin
      if (rst_n && overrun) ov_cnt++;
      if (rst_n && frame_valid && frame_ready) begin
         frames++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got %h, expected no frame", frame_bcd);
         end else begin
            mon_e = exp_q.pop_front();
            check("frame_bcd", 32'(frame_bcd), 32'(mon_e.bcd));
            check("frame_bad", 32'(frame_bad), 32'(mon_e.bad));
         end
      end
   end

   task automatic cyc(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [6:0] s, input logic [ND-1:0] d, input int k);
      seg     = s;
      dig_sel = d;
      cyc(k);
   endtask

   task automatic scan(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                       input logic [6:0] g3);
      drive(g0, 4'b0001, 8);
      drive(g1, 4'b0010, 8);
      drive(g2, 4'b0100, 8);
      drive(g3, 4'b1000, 8);
   endtask

   // Returns just after the edge on which digit 3 latches.
   task automatic scan_to_latch(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                                input logic [6:0] g3);
      drive(g0, 4'b0001, 8);
      drive(g1, 4'b0010, 8);
      drive(g2, 4'b0100, 8);
      drive(g3, 4'b1000, SC + 1 + LAT);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "timeout");
   end

   initial begin
      cyc(2);
      check("rst_valid", 32'(frame_valid), 32'd0);
      check("rst_bcd", 32'(frame_bcd), 32'd0);
      check("rst_bad", 32'(frame_bad), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // Nominal frame, valid one cycle after the final latch
      push_exp(16'h3210, 4'h0);
      scan_to_latch(7'h7E, 7'h30, 7'h6D, 7'h79);
      check("nom_valid_at_latch", 32'(frame_valid), 32'd0);
      cyc(1);
      check("nom_valid_rise", 32'(frame_valid), 32'd1);
      check("nom_bcd", 32'(frame_bcd), 32'h3210);
      check("nom_bad", 32'(frame_bad), 32'd0);
      cyc(3);
      check("nom_valid_hold", 32'(frame_valid), 32'd1);
      frame_ready = 1'b1;
      cyc(1);
      check("nom_valid_drop", 32'(frame_valid), 32'd0);
      frame_ready = 1'b0;

      // Debounce: short 5B ignored, 5F latched; multi-hot glitch never latches
      push_exp(16'h3260, 4'h0);
      drive(7'h7E, 4'b0001, 8);
      drive(7'h5B, 4'b0010, 3);
      drive(7'h5F, 4'b0010, 6);
      drive(7'h30, 4'b0011, 1);
      drive(7'h6D, 4'b0100, 8);
      drive(7'h79, 4'b1000, 8);
      check("deb_valid", 32'(frame_valid), 32'd1);
      frame_ready = 1'b1;
      cyc(1);
      frame_ready = 1'b0;

      // Blank and illegal glyphs, then backpressure through a second frame
      push_exp(16'hFF41, 4'b1000);
      scan(7'h30, 7'h33, 7'h00, 7'h49);
      check("blank_valid", 32'(frame_valid), 32'd1);
      scan(7'h5B, 7'h70, 7'h7F, 7'h7B);
      check("bp_overrun_count", 32'(ov_cnt), 32'd1);
      check("bp_bcd_held", 32'(frame_bcd), 32'hFF41);
      check("bp_bad_held", 32'(frame_bad), 32'b1000);
      check("bp_valid_held", 32'(frame_valid), 32'd1);
      frame_ready = 1'b1;
      cyc(1);
      check("bp_valid_drop", 32'(frame_valid), 32'd0);
      frame_ready = 1'b0;

      // Accept and completion on the same edge
      push_exp(16'h4321, 4'h0);
      scan(7'h30, 7'h6D, 7'h79, 7'h33);
      push_exp(16'h6789, 4'h0);
      scan_to_latch(7'h7B, 7'h7F, 7'h70, 7'h5F);
      frame_ready = 1'b1;
      cyc(1);
      check("sim_valid_stays", 32'(frame_valid), 32'd1);
      check("sim_bcd_new", 32'(frame_bcd), 32'h6789);
      check("sim_no_overrun", 32'(ov_cnt), 32'd1);
      cyc(1);
      check("sim_valid_drop", 32'(frame_valid), 32'd0);
      frame_ready = 1'b0;

      // Reset mid-frame while a frame is presented
      scan(7'h7F, 7'h7F, 7'h7F, 7'h7F);
      check("rstm_valid_before", 32'(frame_valid), 32'd1);
      drive(7'h7E, 4'b0001, 8);
      drive(7'h30, 4'b0010, 8);
      rst_n = 1'b0;
      #1;
      check("rstm_valid", 32'(frame_valid), 32'd0);
      check("rstm_bcd", 32'(frame_bcd), 32'd0);
      check("rstm_bad", 32'(frame_bad), 32'd0);
      seg     = '0;
      dig_sel = '0;
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      push_exp(16'h3210, 4'h0);
      scan_to_latch(7'h7E, 7'h30, 7'h6D, 7'h79);
      check("post_rst_valid_at_latch", 32'(frame_valid), 32'd0);
      cyc(1);
      check("post_rst_valid_rise", 32'(frame_valid), 32'd1);
      frame_ready = 1'b1;
      cyc(1);
      frame_ready = 1'b0;
      cyc(10);
      check("post_rst_single_frame", 32'(frame_valid), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("frame_count", 32'(frames), 32'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
